// File: rtl/memory_game_pkg.sv
// Shared types and constants for the memory-card game.
// Card symbols are SYM_W-bit codes packed into the board word.
package memory_game_pkg;

  localparam int NUM_CARDS = 16;
  localparam int NUM_PAIRS = 8;
  localparam int SYM_W     = 3;
  localparam int BOARD_W   = NUM_CARDS * SYM_W;

  typedef enum logic [2:0] {
    WAIT_FIRST,
    WAIT_SECOND,
    SHOW,
    COMPARE,
    DONE
  } state_t;

  localparam logic [1:0] WIN_PLAYING = 2'b00;
  localparam logic [1:0] WIN_P1      = 2'b01;
  localparam logic [1:0] WIN_P2      = 2'b10;
  localparam logic [1:0] WIN_TIE     = 2'b11;

  function automatic logic [SYM_W-1:0] card_sym(
    input logic [BOARD_W-1:0] board,
    input logic [3:0]         idx
  );
    return board[idx*SYM_W +: SYM_W];
  endfunction

endpackage

// File: rtl/game_result.sv
// Win-code decoder from the registered score and pair counts.
// Shared with the scoreboard display.
module game_result
  import memory_game_pkg::*;
(
  input  logic [3:0] player1,
  input  logic [3:0] player2,
  input  logic [3:0] parejas,
  output logic [1:0] win
);

  always_comb begin
    win = WIN_PLAYING;
    priority case (1'b1)
      (parejas < 4'(NUM_PAIRS)): win = WIN_PLAYING;
      (player1 == player2):      win = WIN_TIE;
      (player1 > player2):       win = WIN_P1;
      default:                   win = WIN_P2;
    endcase
  end

endmodule

// File: rtl/memory_turn_ctrl.sv
// Turn sequencer for the two-player memory game: reveals two
// cards per turn, compares them, keeps scores and turn timeout.
module memory_turn_ctrl
  import memory_game_pkg::*;
#(
  parameter int unsigned SHOW_CYCLES = 25_000_000,
  parameter int unsigned TURN_CYCLES = 500_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 new_game,
  input  logic                 sel_valid,
  input  logic [3:0]           sel_idx,
  input  logic [BOARD_W-1:0]   board,
  output logic                 sel_ready,
  output logic                 turn,
  output logic [3:0]           player1,
  output logic [3:0]           player2,
  output logic [3:0]           parejas,
  output logic [NUM_CARDS-1:0] revealed,
  output logic [NUM_CARDS-1:0] matched,
  output logic                 match_pulse,
  output logic [1:0]           win
);

  localparam int SW = $clog2(SHOW_CYCLES + 1);
  localparam int TW = $clog2(TURN_CYCLES + 1);
  localparam logic [SW-1:0] SHOW_LOAD = SW'(SHOW_CYCLES - 1);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYCLES - 1);

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    idx_a;
  logic [3:0]    idx_b;
  logic [SW-1:0] show_cnt;
  logic [TW-1:0] turn_cnt;
  logic          accept;
  logic          timeout;
  logic          show_done;
  logic          pair_eq;
  logic          last_pair;

  always_comb begin
    sel_ready = (state == WAIT_FIRST) || (state == WAIT_SECOND);
    accept    = sel_valid && sel_ready
                && !matched[sel_idx] && !revealed[sel_idx];
    // a selection landing on the timeout cycle takes precedence
    timeout   = sel_ready && !accept && (turn_cnt == TURN_LAST);
    show_done = (show_cnt == '0);
    pair_eq   = card_sym(board, idx_a) == card_sym(board, idx_b);
    last_pair = (parejas == 4'(NUM_PAIRS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_FIRST;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (new_game) begin
      state_nxt = WAIT_FIRST;
    end else begin
      unique case (state)
        WAIT_FIRST: begin
          if (accept) state_nxt = WAIT_SECOND;
        end
        WAIT_SECOND: begin
          if (accept)       state_nxt = SHOW;
          else if (timeout) state_nxt = WAIT_FIRST;
        end
        SHOW: begin
          if (show_done) state_nxt = COMPARE;
        end
        COMPARE: begin
          state_nxt = (pair_eq && last_pair) ? DONE : WAIT_FIRST;
        end
        DONE:    state_nxt = DONE;
        default: state_nxt = WAIT_FIRST;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_a       <= '0;
      idx_b       <= '0;
      show_cnt    <= '0;
      turn_cnt    <= '0;
      turn        <= 1'b0;
      player1     <= '0;
      player2     <= '0;
      parejas     <= '0;
      revealed    <= '0;
      matched     <= '0;
      match_pulse <= 1'b0;
    end else if (new_game) begin
      idx_a       <= '0;
      idx_b       <= '0;
      show_cnt    <= '0;
      turn_cnt    <= '0;
      turn        <= 1'b0;
      player1     <= '0;
      player2     <= '0;
      parejas     <= '0;
      revealed    <= '0;
      matched     <= '0;
      match_pulse <= 1'b0;
    end else begin
      match_pulse <= 1'b0;
      unique case (state)
        WAIT_FIRST, WAIT_SECOND: begin
          if (accept) begin
            revealed[sel_idx] <= 1'b1;
            turn_cnt          <= '0;
            if (state == WAIT_FIRST) begin
              idx_a <= sel_idx;
            end else begin
              idx_b    <= sel_idx;
              show_cnt <= SHOW_LOAD;
            end
          end else if (timeout) begin
            revealed <= '0;
            turn     <= ~turn;
            turn_cnt <= '0;
          end else begin
            turn_cnt <= turn_cnt + TW'(1);
          end
        end
        SHOW: begin
          if (!show_done) show_cnt <= show_cnt - SW'(1);
        end
        COMPARE: begin
          revealed <= '0;
          turn_cnt <= '0;
          if (pair_eq) begin
            matched     <= matched | revealed;
            parejas     <= parejas + 4'd1;
            match_pulse <= 1'b1;
            if (turn) player2 <= player2 + 4'd1;
            else      player1 <= player1 + 4'd1;
          end else begin
            turn <= ~turn;
          end
        end
        default: ;
      endcase
    end
  end

  game_result u_result (
    .player1 (player1),
    .player2 (player2),
    .parejas (parejas),
    .win     (win)
  );

endmodule

// File: tb/tb_memory_turn_ctrl.sv
// Randomized bench for memory_turn_ctrl against a game-level
// model (face-up list, hold countdown, idle counter, scores).
module tb_memory_turn_ctrl;

  localparam int SHOW = 4;
  localparam int TURN = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        new_game = 1'b0;
  logic        sel_valid = 1'b0;
  logic [3:0]  sel_idx = '0;
  logic [47:0] board = '0;
  logic        sel_ready;
  logic        turn;
  logic [3:0]  player1;
  logic [3:0]  player2;
  logic [3:0]  parejas;
  logic [15:0] revealed;
  logic [15:0] matched;
  logic        match_pulse;
  logic [1:0]  win;

  memory_turn_ctrl #(
    .SHOW_CYCLES (SHOW),
    .TURN_CYCLES (TURN)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .new_game    (new_game),
    .sel_valid   (sel_valid),
    .sel_idx     (sel_idx),
    .board       (board),
    .sel_ready   (sel_ready),
    .turn        (turn),
    .player1     (player1),
    .player2     (player2),
    .parejas     (parejas),
    .revealed    (revealed),
    .matched     (matched),
    .match_pulse (match_pulse),
    .win         (win)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // game-level model
  bit gone[16];
  int picks[$];
  int hold, idle, cur, found;
  int score[2];
  bit pulse;

  function automatic int sym(int i);
    return int'(board[3*i +: 3]);
  endfunction

  function automatic bit is_up(int i);
    foreach (picks[k]) if (picks[k] == i) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    foreach (gone[k]) gone[k] = 1'b0;
    picks.delete();
    hold = 0; idle = 0; cur = 0; found = 0;
    score[0] = 0; score[1] = 0;
    pulse = 1'b0;
  endtask

  task automatic model_step(bit ng, bit sv, int si);
    pulse = 1'b0;
    if (ng) begin
      model_clear();
      return;
    end
    if (found == 8) return;
    if (picks.size() == 2) begin
      hold--;
      if (hold == 0) begin
        if (sym(picks[0]) == sym(picks[1])) begin
          gone[picks[0]] = 1'b1;
          gone[picks[1]] = 1'b1;
          score[cur]++;
          found++;
          pulse = 1'b1;
        end else begin
          cur ^= 1;
        end
        picks.delete();
        idle = 0;
      end
      return;
    end
    if (sv && !gone[si] && !is_up(si)) begin
      picks.push_back(si);
      idle = 0;
      if (picks.size() == 2) hold = SHOW + 1;
    end else begin
      idle++;
      if (idle == TURN) begin
        picks.delete();
        cur ^= 1;
        idle = 0;
      end
    end
  endtask

  function automatic logic [15:0] exp_revealed();
    logic [15:0] r = '0;
    foreach (picks[k]) r[picks[k]] = 1'b1;
    return r;
  endfunction

  function automatic logic [15:0] exp_matched();
    logic [15:0] m = '0;
    foreach (gone[k]) m[k] = gone[k];
    return m;
  endfunction

  function automatic logic [1:0] exp_win();
    if (found < 8) return 2'b00;
    if (score[0] == score[1]) return 2'b11;
    if (score[0] > score[1]) return 2'b01;
    return 2'b10;
  endfunction

  task automatic compare_all();
    check("revealed", revealed, exp_revealed());
    check("matched", matched, exp_matched());
    check("turn", turn, cur);
    check("player1", player1, score[0]);
    check("player2", player2, score[1]);
    check("parejas", parejas, found);
    check("match_pulse", match_pulse, pulse);
    check("win", win, exp_win());
    check("sel_ready", sel_ready, found < 8 && picks.size() < 2);
  endtask

  // called at a falling edge; returns at the next falling edge
  task automatic cyc(bit ng, bit sv, int si);
    new_game  = ng;
    sel_valid = sv;
    sel_idx   = 4'(si);
    model_step(ng, sv, si);
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    new_game  = 1'b0;
    sel_valid = 1'b0;
  endtask

  task automatic pick(int i);
    cyc(1'b0, 1'b1, i);
  endtask

  task automatic wait_cycles(int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 0);
  endtask

  task automatic play(int a, int b);
    pick(a);
    pick(b);
    wait_cycles(SHOW + 1);
  endtask

  task automatic rand_board();
    int s[16];
    for (int k = 0; k < 16; k++) s[k] = k / 2;
    for (int k = 15; k > 0; k--) begin
      int j = int'($urandom_range(0, k));
      int t = s[k];
      s[k] = s[j];
      s[j] = t;
    end
    for (int k = 0; k < 16; k++) board[3*k +: 3] = 3'(s[k]);
  endtask

  function automatic int partner(int p);
    for (int j = 0; j < 16; j++)
      if (j != p && sym(j) == sym(p)) return j;
    return p;
  endfunction

  initial begin
    int sa[16] = '{5, 5, 0, 1, 0, 1, 2, 2, 3, 3, 4, 4, 6, 6, 7, 7};
    for (int k = 0; k < 16; k++) board[3*k +: 3] = 3'(sa[k]);
    model_clear();
    @(negedge clk);
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    // match on cards 0/1
    pick(0);
    pick(1);
    for (int k = 0; k < SHOW; k++) begin
      cyc(1'b0, 1'b0, 0);
      check("show_revealed", revealed, 16'h0003);
    end
    cyc(1'b0, 1'b0, 0);
    check("match_matched", matched, 16'h0003);
    check("match_p1", player1, 1);
    check("match_parejas", parejas, 1);
    check("match_pulse_hi", match_pulse, 1);
    check("match_turn", turn, 0);
    cyc(1'b0, 1'b0, 0);
    check("match_pulse_lo", match_pulse, 0);

    // illegal selections, then a miss
    pick(0);
    check("pick_matched", revealed, 16'h0000);
    pick(2);
    pick(2);
    check("pick_twice", revealed, 16'h0004);
    check("pick_twice_rdy", sel_ready, 1);
    pick(3);
    pick(6);
    check("pick_in_show", revealed, 16'h000C);
    wait_cycles(SHOW);
    check("miss_turn", turn, 1);
    check("miss_revealed", revealed, 16'h0000);
    check("miss_p1", player1, 1);

    // timeout, then selection on the timeout cycle
    pick(4);
    wait_cycles(TURN - 1);
    check("pre_timeout", revealed, 16'h0010);
    wait_cycles(1);
    check("timeout_rev", revealed, 16'h0000);
    check("timeout_turn", turn, 0);
    pick(4);
    wait_cycles(TURN - 1);
    pick(5);
    check("sel_beats_tmo", revealed, 16'h0030);
    check("sel_beats_rdy", sel_ready, 0);

    // async reset during SHOW
    cyc(1'b0, 1'b0, 0);
    rst_n = 1'b0;
    #1;
    check("rst_revealed", revealed, 0);
    check("rst_matched", matched, 0);
    check("rst_turn", turn, 0);
    check("rst_scores", {player1, player2, parejas}, 0);
    check("rst_win", win, 0);
    check("rst_pulse", match_pulse, 0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 0);
    check("rst_ready", sel_ready, 1);

    // full game 5/3
    for (int k = 0; k < 16; k++) board[3*k +: 3] = 3'(k / 2);
    cyc(1'b1, 1'b0, 0);
    for (int p = 0; p < 5; p++) play(2*p, 2*p + 1);
    play(10, 12);
    for (int p = 5; p < 8; p++) play(2*p, 2*p + 1);
    check("g1_win", win, 2'b01);
    check("g1_parejas", parejas, 8);
    check("g1_ready", sel_ready, 0);
    pick(3);
    wait_cycles(TURN + 2);
    check("g1_hold", win, 2'b01);
    cyc(1'b1, 1'b0, 0);
    check("ng_win", win, 2'b00);
    check("ng_matched", matched, 0);

    // full game 4/4
    for (int p = 0; p < 4; p++) play(2*p, 2*p + 1);
    play(8, 10);
    for (int p = 4; p < 8; p++) play(2*p, 2*p + 1);
    check("g2_win", win, 2'b11);
    cyc(1'b1, 1'b0, 0);
    check("ng2_win", win, 2'b00);

    // randomized play
    rand_board();
    cyc(1'b1, 1'b0, 0);
    for (int c = 0; c < 6000; c++) begin
      bit quiet = ((c / 300) % 3) == 2;
      bit sv;
      int si;
      if ((found == 8 && $urandom_range(0, 7) == 0)
          || $urandom_range(0, 399) == 0) begin
        rand_board();
        cyc(1'b1, 1'b0, 0);
        continue;
      end
      sv = quiet ? ($urandom_range(0, 39) == 0)
                 : ($urandom_range(0, 2) == 0);
      si = int'($urandom_range(0, 15));
      for (int t = 0; t < 3 && gone[si]; t++)
        si = int'($urandom_range(0, 15));
      if (picks.size() == 1 && $urandom_range(0, 1) == 1)
        si = partner(picks[0]);
      cyc(1'b0, sv, si);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/memory_turn_ctrl.md
Name: memory_turn_ctrl

Overview:
- Turn sequencer for the two-player memory-card game on a 16-card board (8 pairs).
- Accepts card selections from the input/cursor logic and reveals two cards per turn.
- After a display interval it compares their symbols and updates the score and pair counters; a miss passes the turn to the other player.
- Outputs drive the VGA card renderer (revealed/matched masks) and the score/result display (player1, player2, parejas, win).

Parameters:
- SHOW_CYCLES, 25_000_000, clock cycles both selected cards stay revealed before comparison (0.5 s at 50 MHz); must be >= 1.
- TURN_CYCLES, 500_000_000, clock cycles a player may idle in a turn before forfeiting it (10 s at 50 MHz); must be >= 1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- new_game  input  1  single-cycle pulse: restart game
- sel_valid  input  1  single-cycle pulse: card selected
- sel_idx  input  4  index of selected card, 0..15
- board  input  48  symbol table; card i symbol = board[3i+2:3i]; held stable during a game
- sel_ready  output  1  high in WAIT_FIRST/WAIT_SECOND
- turn  output  1  0 = player 1 to move, 1 = player 2
- player1  output  4  pairs won by player 1
- player2  output  4  pairs won by player 2
- parejas  output  4  total pairs found, 0..8
- revealed  output  16  cards currently face-up this turn
- matched  output  16  cards permanently removed
- match_pulse  output  1  one-cycle pulse on a successful pair
- win  output  2  00 playing, 01 player 1 won, 10 player 2 won, 11 tie

Behaviour:
- Reset (async, rst_n=0): state WAIT_FIRST; all counters, masks, turn, match_pulse = 0; win = 00.
- States: WAIT_FIRST, WAIT_SECOND, SHOW, COMPARE, DONE.
- Accepted selection: sel_valid=1 and sel_ready=1 and matched[sel_idx]=0 and revealed[sel_idx]=0. Any other sel_valid is silently ignored; no state change, turn timer not reset.
- WAIT_FIRST, accepted: latch idx A; set revealed[A]; -> WAIT_SECOND; turn timer reloads.
- WAIT_SECOND, accepted: latch idx B; set revealed[B]; -> SHOW; show counter = SHOW_CYCLES-1.
- Turn timer (WAIT_FIRST/WAIT_SECOND): counts cycles since entering WAIT_FIRST or since the last accepted selection.
- Timeout, when TURN_CYCLES elapse: revealed cleared; turn toggles; -> WAIT_FIRST.
- Simultaneous accepted selection and timeout: the selection wins.
- SHOW: counter decrements each cycle; at 0 -> COMPARE. Selections are ignored.
- COMPARE (exactly one cycle) evaluates symbol(A) == symbol(B):
  - Equal: matched |= revealed; score of current player +1; parejas +1; match_pulse=1 next cycle; turn unchanged.
  - Not equal: turn toggles.
  - Either way: revealed cleared; next state DONE if the updated parejas == 8, else WAIT_FIRST.
- DONE: sel_ready=0; all outputs hold until new_game or reset.
- new_game, any state: synchronous clear to reset values next cycle; has priority over every other event in that cycle.
- Widths: counts saturate by construction (max 8) and need no overflow logic.
- Win code (pure combinational from the registered counts):
  - parejas < 8 -> 00.
  - parejas = 8: player1 == player2 -> 11; player1 > player2 -> 01; else 10.
- Timing: win reflects the last pair in the cycle parejas becomes 8.
- Latency, second accepted selection to score update: SHOW_CYCLES + 1 cycles.

Decomposition:
- Shared package memory_game_pkg holds:
  - state enum;
  - win codes WIN_PLAYING=2'b00, WIN_P1=2'b01, WIN_P2=2'b10, WIN_TIE=2'b11;
  - NUM_CARDS=16, NUM_PAIRS=8, SYM_W=3.
- One sub-module, game_result: combinational win-code decoder (player1, player2, parejas -> win), reused by the scoreboard display.
- Counters and FSM stay in memory_turn_ctrl.

Test Plan (bench uses SHOW_CYCLES=4, TURN_CYCLES=20):
- Reset: rst_n=0 mid-SHOW -> all outputs 0 immediately (async), state WAIT_FIRST; on rst_n=1, sel_ready=1.
- Match: board[2:0]=board[5:3]=3'd5; select 0 then 1 -> revealed=16'h0003 for 4 cycles; then matched=16'h0003, player1=1, parejas=1, match_pulse for one cycle, turn stays 0.
- Miss: symbols of cards 2 and 3 differ; select 2, 3 -> revealed cleared, turn=1, scores unchanged.
- Illegal selections:
  - select a matched card -> ignored;
  - select the same card twice -> ignored, still WAIT_SECOND;
  - select during SHOW -> ignored.
- Timeout: select card 4 only, idle 20 cycles -> revealed=0, turn toggles. Same-cycle selection and timeout -> selection accepted.
- Full games:
  - player 1 finds 5 pairs, player 2 finds 3 -> parejas=8, win=01, state DONE, sel_ready=0;
  - 4/4 split -> win=11;
  - new_game -> all cleared, win=00.
